// File: rtl/lock_pkg.sv
// ============================================================================
// Module      : lock_pkg
// Description : Shared state encoding, width helpers and one-hot decode
//               function for the lock code sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lock_pkg;

  localparam logic [2:0] ENC_IDLE     = 3'd0;
  localparam logic [2:0] ENC_ENTRY    = 3'd1;
  localparam logic [2:0] ENC_UNLOCKED = 3'd2;
  localparam logic [2:0] ENC_ERROR    = 3'd3;
  localparam logic [2:0] ENC_LOCKOUT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ENC_IDLE,
    ST_ENTRY    = ENC_ENTRY,
    ST_UNLOCKED = ENC_UNLOCKED,
    ST_ERROR    = ENC_ERROR,
    ST_LOCKOUT  = ENC_LOCKOUT
  } state_t;

  // Widest button vector the one-hot decoder accepts.
  localparam int MAX_BTN = 32;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns 1 when exactly one bit is set; idx receives the highest set bit.
  function automatic logic onehot_valid(input logic [MAX_BTN-1:0] vec, output int idx);
    int ones;
    ones = 0;
    idx  = 0;
    for (int i = 0; i < MAX_BTN; i++) begin
      if (vec[i]) begin
        ones = ones + 1;
        idx  = i;
      end
    end
    return (ones == 1);
  endfunction

endpackage : lock_pkg

`default_nettype wire

// File: rtl/button_index_encoder.sv
// ============================================================================
// Module      : button_index_encoder
// Description : Combinational one-hot button vector to index encoder with a
//               valid flag that is high only when exactly one bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_index_encoder
  import lock_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DW    = width_of(WIDTH)
) (
  input  logic [WIDTH-1:0] i_buttons,
  output logic [DW-1:0]    o_index,
  output logic             o_valid
);

  int idx;

  always_comb begin
    idx     = 0;
    o_valid = onehot_valid(MAX_BTN'(i_buttons), idx);
    o_index = DW'(idx);
  end

endmodule : button_index_encoder

`default_nettype wire

// File: rtl/lock_code_sequencer.sv
// ============================================================================
// Module      : lock_code_sequencer
// Description : Digital lock controller FSM: sequences code entry from button
//               edge pulses, drives lock status, error pulse and lockout.
//               Optional macro ENTRY_TIMEOUT_EN adds a mid-entry inactivity
//               timeout that abandons a partial entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_code_sequencer
  import lock_pkg::*;
#(
  parameter int                                  WIDTH          = 4,
  parameter int                                  CODE_LEN       = 4,
  parameter logic [CODE_LEN*width_of(WIDTH)-1:0] DEFAULT_CODE   = 8'hE4,
  parameter int                                  MAX_ATTEMPTS   = 3,
  parameter int                                  LOCKOUT_CYCLES = 16,
  parameter int                                  TIMEOUT_CYCLES = 64
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [WIDTH-1:0]                      buttonEdge,
  input  logic                                  lockRequest,
  output logic                                  locked,
  output logic                                  unlocked,
  output logic                                  error,
  output logic                                  lockout,
  output logic [width_of(CODE_LEN+1)-1:0]       digitCount,
  output logic [width_of(MAX_ATTEMPTS+1)-1:0]   attempts
);

  localparam int DW = width_of(WIDTH);
  localparam int CW = width_of(CODE_LEN + 1);
  localparam int AW = width_of(MAX_ATTEMPTS + 1);
  localparam int LW = width_of(LOCKOUT_CYCLES);

  if (WIDTH < 1 || WIDTH > MAX_BTN) begin : g_width_check
    $error("lock_code_sequencer: WIDTH out of range");
  end
  if (CODE_LEN < 1 || MAX_ATTEMPTS < 1) begin : g_count_check
    $error("lock_code_sequencer: CODE_LEN and MAX_ATTEMPTS must be positive");
  end
  if (LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cycles_check
    $error("lock_code_sequencer: cycle counts must be positive");
  end

  state_t          state_q, state_d;
  logic            locked_q, locked_d;
  logic            unlocked_q, unlocked_d;
  logic            error_q, error_d;
  logic            lockout_q, lockout_d;
  logic [CW-1:0]   digit_count_q, digit_count_d;
  logic [AW-1:0]   attempts_q, attempts_d;
  logic            mismatch_q, mismatch_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = width_of(TIMEOUT_CYCLES);
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
`endif

  logic            press;
  logic [DW-1:0]   btn_index;
  logic            btn_valid;
  logic [DW-1:0]   code_digit;
  logic            digit_bad;
  logic            mismatch_all;
  logic [CW-1:0]   count_inc;
  logic [AW-1:0]   attempts_inc;

  button_index_encoder #(
    .WIDTH (WIDTH),
    .DW    (DW)
  ) u_encoder (
    .i_buttons (buttonEdge),
    .o_index   (btn_index),
    .o_valid   (btn_valid)
  );

  assign press = |buttonEdge;

  // Expected digit for the press that is about to be recorded.
  always_comb begin
    code_digit = '0;
    for (int k = 0; k < CODE_LEN; k++) begin
      if (digit_count_q == CW'(k)) begin
        code_digit = DEFAULT_CODE[k*DW +: DW];
      end
    end
  end

  assign digit_bad    = !btn_valid || (btn_index != code_digit);
  assign mismatch_all = mismatch_q | digit_bad;
  assign count_inc    = digit_count_q + CW'(1);
  assign attempts_inc = (attempts_q == AW'(MAX_ATTEMPTS)) ? attempts_q : attempts_q + AW'(1);

  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    mismatch_d    = mismatch_q;
    attempts_d    = attempts_q;
    lock_cnt_d    = lock_cnt_q;
`ifdef ENTRY_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (press) begin
          if (count_inc == CW'(CODE_LEN)) begin
            digit_count_d = '0;
            mismatch_d    = 1'b0;
            if (mismatch_all) begin
              state_d    = ST_ERROR;
              attempts_d = attempts_inc;
            end else begin
              state_d    = ST_UNLOCKED;
              attempts_d = '0;
            end
          end else begin
            state_d       = ST_ENTRY;
            digit_count_d = count_inc;
            mismatch_d    = mismatch_all;
`ifdef ENTRY_TIMEOUT_EN
            tmo_cnt_d     = TW'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (state_q == ST_ENTRY) begin
          if (tmo_cnt_q == '0) begin
            state_d       = ST_IDLE;
            digit_count_d = '0;
            mismatch_d    = 1'b0;
          end else begin
            tmo_cnt_d = tmo_cnt_q - TW'(1);
          end
        end
`endif
      end

      // A press here only relocks; it is never recorded as a digit.
      ST_UNLOCKED: begin
        if (lockRequest || press) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERROR: begin
        if (attempts_q == AW'(MAX_ATTEMPTS)) begin
          state_d    = ST_LOCKOUT;
          lock_cnt_d = LW'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (lock_cnt_q == '0) begin
          state_d    = ST_IDLE;
          attempts_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - LW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    locked_d   = (state_d != ST_UNLOCKED);
    unlocked_d = (state_d == ST_UNLOCKED);
    error_d    = (state_d == ST_ERROR);
    lockout_d  = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      locked_q      <= 1'b1;
      unlocked_q    <= 1'b0;
      error_q       <= 1'b0;
      lockout_q     <= 1'b0;
      digit_count_q <= '0;
      attempts_q    <= '0;
      mismatch_q    <= 1'b0;
      lock_cnt_q    <= '0;
`ifdef ENTRY_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      locked_q      <= locked_d;
      unlocked_q    <= unlocked_d;
      error_q       <= error_d;
      lockout_q     <= lockout_d;
      digit_count_q <= digit_count_d;
      attempts_q    <= attempts_d;
      mismatch_q    <= mismatch_d;
      lock_cnt_q    <= lock_cnt_d;
`ifdef ENTRY_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign locked     = locked_q;
  assign unlocked   = unlocked_q;
  assign error      = error_q;
  assign lockout    = lockout_q;
  assign digitCount = digit_count_q;
  assign attempts   = attempts_q;

endmodule : lock_code_sequencer

`default_nettype wire

// File: tb/tb_lock_code_sequencer.sv
// ============================================================================
// Module      : tb_lock_code_sequencer
// Description : Self-checking bench for lock_code_sequencer (table of
//               per-cycle vectors plus hand-written lockout/reset/timeout runs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lock_code_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttonEdge = '0;
  logic       lockRequest = 1'b0;
  logic       locked, unlocked, error, lockout;
  logic [2:0] digitCount;
  logic [1:0] attempts;

  always #5 clock = ~clock;

  lock_code_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .buttonEdge  (buttonEdge),
    .lockRequest (lockRequest),
    .locked      (locked),
    .unlocked    (unlocked),
    .error       (error),
    .lockout     (lockout),
    .digitCount  (digitCount),
    .attempts    (attempts)
  );

  // Expected output word: {locked, unlocked, error, lockout, digitCount, attempts}
  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] btn;
    logic       req;
    logic [8:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] sb[$];
  int         checks   = 0;
  int         failures = 0;

  function automatic logic [8:0] st_idle(input logic [2:0] dc, input logic [1:0] at);
    return {1'b1, 1'b0, 1'b0, 1'b0, dc, at};
  endfunction
  function automatic logic [8:0] st_unl();
    return {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
  endfunction
  function automatic logic [8:0] st_err(input logic [1:0] at);
    return {1'b1, 1'b0, 1'b1, 1'b0, 3'd0, at};
  endfunction
  function automatic logic [8:0] st_lko(input logic [1:0] at);
    return {1'b1, 1'b0, 1'b0, 1'b1, 3'd0, at};
  endfunction

  function automatic void add(input string name, input logic rst, input logic [3:0] btn,
                              input logic req, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.btn = btn; v.req = req; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Four presses; the final one lands in UNLOCKED or ERROR depending on good.
  function automatic void add_entry(input string name, input logic [3:0] b0, input logic [3:0] b1,
                                    input logic [3:0] b2, input logic [3:0] b3,
                                    input logic [1:0] at, input logic good);
    add(name, 1'b0, b0, 1'b0, st_idle(3'd1, at));
    add(name, 1'b0, b1, 1'b0, st_idle(3'd2, at));
    add(name, 1'b0, b2, 1'b0, st_idle(3'd3, at));
    add(name, 1'b0, b3, 1'b0, good ? st_unl() : st_err(at + 2'd1));
  endfunction

  task automatic step(input vec_t v);
    logic [8:0] got, want;
    @(negedge clock);
    reset       = v.rst;
    buttonEdge  = v.btn;
    lockRequest = v.req;
    sb.push_back(v.exp);
    @(posedge clock);
    #1;
    got  = {locked, unlocked, error, lockout, digitCount, attempts};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s @%0t: got locked=%b unlocked=%b error=%b lockout=%b digitCount=%0d attempts=%0d; want locked=%b unlocked=%b error=%b lockout=%b digitCount=%0d attempts=%0d",
               v.name, $time, got[8], got[7], got[6], got[5], got[4:2], got[1:0],
               want[8], want[7], want[6], want[5], want[4:2], want[1:0]);
    end
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) step(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, correct code, relock by request, lockRequest in IDLE is a no-op.
    add("reset", 1'b1, 4'b0000, 1'b0, st_idle(3'd0, 2'd0));
    add("reset", 1'b1, 4'b0000, 1'b0, st_idle(3'd0, 2'd0));
    add_entry("code_ok", 4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'd0, 1'b1);
    add("unl_hold",   1'b0, 4'b0000, 1'b0, st_unl());
    add("relock_req", 1'b0, 4'b0000, 1'b1, st_idle(3'd0, 2'd0));
    add("idle_req",   1'b0, 4'b0000, 1'b1, st_idle(3'd0, 2'd0));
    // Press while unlocked relocks without recording a digit.
    add_entry("code_ok2", 4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'd0, 1'b1);
    add("relock_press", 1'b0, 4'b0100, 1'b0, st_idle(3'd0, 2'd0));
    add_entry("code_ok3", 4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'd0, 1'b1);
    add("relock_both", 1'b0, 4'b0001, 1'b1, st_idle(3'd0, 2'd0));
    add("after_both",  1'b0, 4'b0000, 1'b0, st_idle(3'd0, 2'd0));
    // Three wrong entries lead to a 16-cycle lockout.
    add_entry("wrong1", 4'b0001, 4'b0010, 4'b0100, 4'b0100, 2'd0, 1'b0);
    add("err1_press", 1'b0, 4'b0001, 1'b0, st_idle(3'd0, 2'd1));
    add_entry("wrong2", 4'b0001, 4'b0010, 4'b0100, 4'b0100, 2'd1, 1'b0);
    add("err2_done", 1'b0, 4'b0000, 1'b1, st_idle(3'd0, 2'd2));
    add_entry("wrong3", 4'b0001, 4'b0010, 4'b0100, 4'b0100, 2'd2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] b;
      b = 4'b0001 << (i % 4);
      add("lockout", 1'b0, b, i[0], st_lko(2'd3));
    end
    add("lockout_end", 1'b0, 4'b0000, 1'b0, st_idle(3'd0, 2'd0));
    // Multi-bit press as second digit poisons the entry.
    add_entry("multibit", 4'b0001, 4'b0011, 4'b0100, 4'b1000, 2'd0, 1'b0);
    add("mb_done", 1'b0, 4'b0000, 1'b0, st_idle(3'd0, 2'd1));
    add_entry("recover", 4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'd1, 1'b1);
    add("recover_relock", 1'b0, 4'b0000, 1'b1, st_idle(3'd0, 2'd0));
    run_vecs();

    // Reset during the fifth lockout cycle, then the correct code unlocks.
    for (int r = 0; r < 3; r++) begin
      add_entry("rst_wrong", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 2'(r), 1'b0);
      if (r < 2) add("rst_err_done", 1'b0, 4'b0000, 1'b0, st_idle(3'd0, 2'(r + 1)));
    end
    for (int i = 0; i < 4; i++) add("rst_lockout", 1'b0, 4'b0000, 1'b0, st_lko(2'd3));
    add("rst_in_lockout", 1'b1, 4'b0010, 1'b0, st_idle(3'd0, 2'd0));
    add_entry("rst_code_ok", 4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'd0, 1'b1);
    add("rst_relock", 1'b0, 4'b0000, 1'b1, st_idle(3'd0, 2'd0));
    run_vecs();

    // Partial entry followed by 64 idle cycles.
    add("tmo_press1", 1'b0, 4'b0001, 1'b0, st_idle(3'd1, 2'd0));
    add("tmo_press2", 1'b0, 4'b0010, 1'b0, st_idle(3'd2, 2'd0));
    for (int i = 0; i < 63; i++) add("tmo_wait", 1'b0, 4'b0000, 1'b0, st_idle(3'd2, 2'd0));
`ifdef ENTRY_TIMEOUT_EN
    add("tmo_expire", 1'b0, 4'b0000, 1'b0, st_idle(3'd0, 2'd0));
    add("tmo_after",  1'b0, 4'b0000, 1'b0, st_idle(3'd0, 2'd0));
`else
    add("tmo_expire", 1'b0, 4'b0000, 1'b0, st_idle(3'd2, 2'd0));
    add("tmo_after",  1'b0, 4'b0000, 1'b0, st_idle(3'd2, 2'd0));
`endif
    add("final_reset", 1'b1, 4'b0000, 1'b0, st_idle(3'd0, 2'd0));
    run_vecs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lock_code_sequencer

`default_nettype wire

// File: doc/lock_code_sequencer.md
Name: lock_code_sequencer

Overview:
Controller FSM for the digital lock. It consumes the one-cycle edge pulses from the N-bit button monitor and sequences code entry. It compares entered digits against a stored code, then drives locked/unlocked status, error pulses and an attempt lockout. It sits between the button monitor and the lock status/display logic.

Parameters:
WIDTH, 4, number of buttons; width of buttonEdge
CODE_LEN, 4, digits per code entry
DEFAULT_CODE, 8'hE4, unlock code; digit k occupies bits [k*DW +: DW], where DW = $clog2(WIDTH) and k=0 is the first press (default sequence 0,1,2,3)
MAX_ATTEMPTS, 3, consecutive failed entries before lockout
LOCKOUT_CYCLES, 16, lockout duration in clock cycles
TIMEOUT_CYCLES, 64, inactivity limit mid-entry (optional feature only)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
buttonEdge  input  WIDTH  one-cycle press pulses from the button monitor
lockRequest  input  1  relock command; level-sampled each cycle
locked  output  1  high in every state except UNLOCKED
unlocked  output  1  high in UNLOCKED
error  output  1  one-cycle pulse on a failed entry
lockout  output  1  high during LOCKOUT
digitCount  output  $clog2(CODE_LEN+1)  digits entered in the current attempt
attempts  output  $clog2(MAX_ATTEMPTS+1)  consecutive failures so far

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, locked=1, unlocked=0, error=0, lockout=0, digitCount=0, attempts=0, mismatch flag=0.
- Press definition: any cycle with buttonEdge != 0. A valid digit requires exactly one bit set; the digit value is that bit's index. A multi-bit press counts as one digit and sets mismatch.
- States: IDLE, ENTRY, UNLOCKED, ERROR, LOCKOUT. All outputs are registered.
- IDLE, on press: compare the digit with code digit 0, set mismatch on a difference, digitCount=1, go to ENTRY. If CODE_LEN=1, the final-digit rule below applies instead.
- ENTRY, on press: compare with code digit digitCount and OR the result into mismatch; digitCount increments.
- Final digit (the press that makes digitCount reach CODE_LEN): the decision uses the mismatch flag including that press. Next cycle the FSM enters UNLOCKED if no mismatch, otherwise ERROR. digitCount and mismatch clear in the same transition.
- Latency: unlocked or error rises 1 cycle after the final press edge.
- UNLOCKED: attempts clears to 0. Return to IDLE next cycle on lockRequest=1 or any press; that press is consumed and not recorded as a digit.
- ERROR: lasts exactly 1 cycle with error=1, and attempts increments. If the new attempts == MAX_ATTEMPTS, go to LOCKOUT; otherwise go to IDLE. Presses during ERROR are ignored.
- LOCKOUT: load a down-counter with LOCKOUT_CYCLES-1. lockout=1 and all presses are ignored. When the counter reaches 0, go to IDLE and clear attempts. Total lockout = LOCKOUT_CYCLES cycles.
- lockRequest in IDLE/ENTRY/ERROR/LOCKOUT: no effect.
- lockRequest and a press in the same UNLOCKED cycle: single relock; the press is ignored.
- Reset mid-operation (any state, including LOCKOUT): immediate return to reset values on the next edge.
- attempts saturates at MAX_ATTEMPTS and never wraps.

Optional Feature:
Macro ENTRY_TIMEOUT_EN.
- Defined: an inactivity counter runs in ENTRY and reloads on each accepted press. If TIMEOUT_CYCLES cycles pass with no press, go to IDLE and clear digitCount and mismatch. No error pulse, and attempts is unchanged.
- Undefined: no counter is built; a partial entry waits indefinitely.

Decomposition:
- Package lock_pkg holds the state encoding localparams, the DW/count-width constants, and a function onehot_valid returning a valid flag plus the index.
- One sub-module, button_index_encoder: WIDTH one-hot input to DW index plus a valid output (exactly one bit set). It is combinational and instantiated once.

Test Plan:
- Reset, then presses 0001,0010,0100,1000 on separate cycles -> unlocked=1 one cycle after the 4th pulse; locked=0, attempts=0, digitCount back to 0.
- In UNLOCKED, assert lockRequest for 1 cycle -> locked=1 next cycle, state IDLE. In a separate case, press a button in UNLOCKED -> relock with digitCount staying 0.
- Wrong code 0,1,2,2 -> error pulses for exactly 1 cycle and attempts=1. Repeat twice more -> lockout=1 for exactly 16 cycles, presses ignored (digitCount stays 0), then attempts=0.
- Multi-bit press 0011 as the 2nd digit followed by correct digits -> error, no unlock.
- Reset asserted during LOCKOUT cycle 5 -> all outputs at reset values next cycle; the correct code then unlocks.
- With ENTRY_TIMEOUT_EN: two presses then 64 idle cycles -> digitCount=0, no error, attempts unchanged. Without the macro, digitCount stays 2.
